// File: rtl/mesi_pkg.sv
// Shared encodings for the MESI snooping-bus controller: line states,
// bus messages, memory commands and controller FSM states.
package mesi_pkg;

    localparam int unsigned MSG_W     = 2;
    localparam int unsigned MEM_CMD_W = 2;
    localparam int unsigned STATE_W   = 3;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_state_e;

    typedef enum logic [MSG_W-1:0] {
        MSG_NONE    = 2'd0,
        MSG_RD_MISS = 2'd1,
        MSG_WR_MISS = 2'd2,
        MSG_INV     = 2'd3
    } bus_msg_e;

    typedef enum logic [MEM_CMD_W-1:0] {
        MEM_NONE = 2'd0,
        MEM_READ = 2'd1,
        MEM_WB   = 2'd2
    } mem_cmd_e;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_SNOOP = 3'd1,
        ST_RESP  = 3'd2,
        ST_WB    = 3'd3,
        ST_FETCH = 3'd4,
        ST_DONE  = 3'd5
    } ctrl_state_e;

    // True when more than one bit of the vector is set.
    function automatic logic multi_hot(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

endpackage

// File: rtl/mesi_bus_controller_if.sv
// Cache-side and memory-side signals of the snooping bus controller.
interface mesi_bus_controller_if #(
    parameter int unsigned N_CACHES = 2
);
    import mesi_pkg::*;

    logic [N_CACHES-1:0]   req;
    logic [2*N_CACHES-1:0] req_msg;
    logic [N_CACHES-1:0]   snoop_shared;
    logic [N_CACHES-1:0]   snoop_dirty;
    logic                  mem_ready;

    logic [N_CACHES-1:0]   grant;
    logic                  snoop_valid;
    logic [MSG_W-1:0]      bus_msg;
    logic                  mem_valid;
    logic [MEM_CMD_W-1:0]  mem_cmd;
    logic [N_CACHES-1:0]   done;
    logic                  done_shared;
    logic                  protocol_err;
    logic [STATE_W-1:0]    dbg_state;

    // Controller view.
    modport master (
        input  req, req_msg, snoop_shared, snoop_dirty, mem_ready,
        output grant, snoop_valid, bus_msg, mem_valid, mem_cmd,
               done, done_shared, protocol_err, dbg_state
    );

    // Cache/memory view.
    modport slave (
        output req, req_msg, snoop_shared, snoop_dirty, mem_ready,
        input  grant, snoop_valid, bus_msg, mem_valid, mem_cmd,
               done, done_shared, protocol_err, dbg_state
    );

endinterface

// File: rtl/rr_arbiter.sv
// N-way round-robin picker. r_ptr is the first index searched; after a
// transaction it moves to the index just past the owner, so the owner
// has lowest priority next time.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] i_eligible,
    input  logic         i_update,
    input  logic [N-1:0] i_owner,
    output logic [N-1:0] o_grant_c,
    output logic         o_valid_c
);
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_d;
    logic [IDX_W-1:0] w_idx;

    // Pick the first eligible requester starting at r_ptr, wrapping.
    always_comb begin
        o_grant_c = '0;
        o_valid_c = 1'b0;
        w_idx     = r_ptr;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = IDX_W'((32'(r_ptr) + k) % N);
            if (!o_valid_c && i_eligible[w_idx]) begin
                o_grant_c[w_idx] = 1'b1;
                o_valid_c        = 1'b1;
            end
        end
    end

    // Next search start: one past the one-hot owner.
    always_comb begin
        w_ptr_d = r_ptr;
        for (int unsigned i = 0; i < N; i++) begin
            if (i_owner[i]) begin
                w_ptr_d = IDX_W'((i + 1) % N);
            end
        end
    end

    // Pointer register, advanced when a transaction completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_update) begin
            r_ptr <= w_ptr_d;
        end
    end

endmodule

// File: rtl/mesi_bus_controller.sv
// Snooping-bus controller: arbitrates among caches, broadcasts the
// owner's message, samples snoop responses, sequences write-back and
// fetch, then pulses done to the owner.
module mesi_bus_controller
    import mesi_pkg::*;
#(
    parameter int unsigned N_CACHES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    mesi_bus_controller_if.master bus
);

    ctrl_state_e           r_state, w_state_d;
    logic [N_CACHES-1:0]   w_eligible, w_pick, w_sh_m, w_dt_m;
    logic                  w_pick_valid;
    logic [MSG_W-1:0]      w_pick_msg;
    logic                  w_rr_update;

    logic [N_CACHES-1:0]   r_grant, w_grant_d;
    logic [MSG_W-1:0]      r_msg, w_msg_d;
    logic                  r_hit, w_hit_d;
    logic                  r_perr, w_perr_d;

    logic                  r_snoop_valid, w_snoop_valid_d;
    logic                  r_mem_valid, w_mem_valid_d;
    logic [MEM_CMD_W-1:0]  r_mem_cmd, w_mem_cmd_d;
    logic [N_CACHES-1:0]   r_done, w_done_d;
    logic                  r_done_shared, w_done_shared_d;
    logic [STATE_W-1:0]    r_dbg_state, w_dbg_state_d;

    // A request counts only if it carries a real message.
    always_comb begin
        w_eligible = '0;
        for (int unsigned i = 0; i < N_CACHES; i++) begin
            w_eligible[i] = bus.req[i] && (bus.req_msg[2*i +: 2] != MSG_NONE);
        end
    end

    // Message of the arbitration winner.
    always_comb begin
        w_pick_msg = MSG_NONE;
        for (int unsigned i = 0; i < N_CACHES; i++) begin
            if (w_pick[i]) begin
                w_pick_msg = bus.req_msg[2*i +: 2];
            end
        end
    end

    rr_arbiter #(
        .N (N_CACHES)
    ) u_rr (
        .clock      (clock),
        .reset      (reset),
        .i_eligible (w_eligible),
        .i_update   (w_rr_update),
        .i_owner    (r_grant),
        .o_grant_c  (w_pick),
        .o_valid_c  (w_pick_valid)
    );

    assign w_rr_update = (r_state == ST_DONE);
    assign w_sh_m      = bus.snoop_shared & ~r_grant;
    assign w_dt_m      = bus.snoop_dirty  & ~r_grant;

    // Next state, latched transaction context and next output values.
    always_comb begin
        w_state_d = r_state;
        w_grant_d = r_grant;
        w_msg_d   = r_msg;
        w_hit_d   = r_hit;
        w_perr_d  = r_perr;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_d = ST_SNOOP;
                    w_grant_d = w_pick;
                    w_msg_d   = w_pick_msg;
                    w_hit_d   = 1'b0;
                end
            end
            ST_SNOOP: w_state_d = ST_RESP;
            ST_RESP: begin
                w_hit_d = |(w_sh_m | w_dt_m);
                if (multi_hot(8'(w_dt_m))) begin
                    w_perr_d = 1'b1;
                end
                if (r_msg == MSG_INV) begin
                    w_state_d = ST_DONE;
                end else if (|w_dt_m) begin
                    w_state_d = ST_WB;
                end else begin
                    w_state_d = ST_FETCH;
                end
            end
            ST_WB: begin
                if (bus.mem_ready) begin
                    w_state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    w_state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
                w_grant_d = '0;
                w_msg_d   = MSG_NONE;
                w_hit_d   = 1'b0;
            end
            default: w_state_d = ST_IDLE;
        endcase

        w_snoop_valid_d = (w_state_d == ST_SNOOP);
        w_mem_valid_d   = (w_state_d == ST_WB) || (w_state_d == ST_FETCH);
        w_mem_cmd_d     = MEM_NONE;
        if (w_state_d == ST_WB) begin
            w_mem_cmd_d = MEM_WB;
        end else if (w_state_d == ST_FETCH) begin
            w_mem_cmd_d = MEM_READ;
        end
        w_done_d        = (w_state_d == ST_DONE) ? w_grant_d : '0;
        w_done_shared_d = (w_state_d == ST_DONE) && (w_msg_d == MSG_RD_MISS) && w_hit_d;
        w_dbg_state_d   = w_state_d;
    end

    // State, context and registered outputs; reset aborts any transaction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_msg         <= MSG_NONE;
            r_hit         <= 1'b0;
            r_perr        <= 1'b0;
            r_snoop_valid <= 1'b0;
            r_mem_valid   <= 1'b0;
            r_mem_cmd     <= MEM_NONE;
            r_done        <= '0;
            r_done_shared <= 1'b0;
            r_dbg_state   <= '0;
        end else begin
            r_state       <= w_state_d;
            r_grant       <= w_grant_d;
            r_msg         <= w_msg_d;
            r_hit         <= w_hit_d;
            r_perr        <= w_perr_d;
            r_snoop_valid <= w_snoop_valid_d;
            r_mem_valid   <= w_mem_valid_d;
            r_mem_cmd     <= w_mem_cmd_d;
            r_done        <= w_done_d;
            r_done_shared <= w_done_shared_d;
            r_dbg_state   <= w_dbg_state_d;
        end
    end

    assign bus.grant        = r_grant;
    assign bus.snoop_valid  = r_snoop_valid;
    assign bus.bus_msg      = r_msg;
    assign bus.mem_valid    = r_mem_valid;
    assign bus.mem_cmd      = r_mem_cmd;
    assign bus.done         = r_done;
    assign bus.done_shared  = r_done_shared;
    assign bus.protocol_err = r_perr;
    assign bus.dbg_state    = r_dbg_state;

endmodule

// File: tb/tb_mesi_bus_controller.sv
// Directed bench for the MESI bus controller: a 2-cache and a 3-cache
// instance, outputs sampled on the falling clock edge.
module tb_mesi_bus_controller;

    logic clock;
    logic reset;

    int unsigned n_cmp;
    int unsigned n_mis;
    int          n;

    mesi_bus_controller_if #(.N_CACHES(2)) bif2 ();
    mesi_bus_controller_if #(.N_CACHES(3)) bif3 ();

    mesi_bus_controller #(.N_CACHES(2)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bif2)
    );

    mesi_bus_controller #(.N_CACHES(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bif3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk2_zero(input string tag);
        chk({tag, ".grant"},   8'(bif2.grant),        8'h0);
        chk({tag, ".snoopv"},  8'(bif2.snoop_valid),  8'h0);
        chk({tag, ".busmsg"},  8'(bif2.bus_msg),      8'h0);
        chk({tag, ".memv"},    8'(bif2.mem_valid),    8'h0);
        chk({tag, ".memcmd"},  8'(bif2.mem_cmd),      8'h0);
        chk({tag, ".done"},    8'(bif2.done),         8'h0);
        chk({tag, ".dshared"}, 8'(bif2.done_shared),  8'h0);
        chk({tag, ".perr"},    8'(bif2.protocol_err), 8'h0);
        chk({tag, ".dbg"},     8'(bif2.dbg_state),    8'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        reset = 1'b1;
        bif2.req = '0; bif2.req_msg = '0; bif2.snoop_shared = '0; bif2.snoop_dirty = '0; bif2.mem_ready = 1'b0;
        bif3.req = '0; bif3.req_msg = '0; bif3.snoop_shared = '0; bif3.snoop_dirty = '0; bif3.mem_ready = 1'b0;

        repeat (2) @(negedge clock);
        chk2_zero("rst");
        chk("rst3.dbg",  8'(bif3.dbg_state),    8'h0);
        chk("rst3.perr", 8'(bif3.protocol_err), 8'h0);
        reset = 1'b0;

        // Request with MSG_NONE is ignored
        bif2.req = 2'b01; bif2.req_msg = 4'b0000;
        repeat (2) @(negedge clock);
        chk("inelig.dbg",   8'(bif2.dbg_state), 8'h0);
        chk("inelig.grant", 8'(bif2.grant),     8'h0);

        // Clean read miss from cache 0
        bif2.req_msg = 4'b0001; bif2.mem_ready = 1'b1;
        @(negedge clock);
        chk("clean.grant",  8'(bif2.grant),       8'h1);
        chk("clean.snoopv", 8'(bif2.snoop_valid), 8'h1);
        chk("clean.busmsg", 8'(bif2.bus_msg),     8'h1);
        chk("clean.dbg1",   8'(bif2.dbg_state),   8'h1);
        @(negedge clock);
        chk("clean.snoopv0", 8'(bif2.snoop_valid), 8'h0);
        chk("clean.dbg2",    8'(bif2.dbg_state),   8'h2);
        @(negedge clock);
        chk("clean.memv",   8'(bif2.mem_valid), 8'h1);
        chk("clean.memcmd", 8'(bif2.mem_cmd),   8'h1);
        chk("clean.dbg4",   8'(bif2.dbg_state), 8'h4);
        @(negedge clock);
        chk("clean.done",    8'(bif2.done),        8'h1);
        chk("clean.dshared", 8'(bif2.done_shared), 8'h0);
        chk("clean.memv0",   8'(bif2.mem_valid),   8'h0);
        chk("clean.dbg5",    8'(bif2.dbg_state),   8'h5);
        bif2.req = 2'b00;
        @(negedge clock);
        chk("clean.idle.done",  8'(bif2.done),    8'h0);
        chk("clean.idle.grant", 8'(bif2.grant),   8'h0);
        chk("clean.idle.msg",   8'(bif2.bus_msg), 8'h0);
        chk("clean.idle.dbg",   8'(bif2.dbg_state), 8'h0);

        // Dirty read miss: cache 1 holds the line in M
        bif2.req = 2'b01; bif2.req_msg = 4'b0001; bif2.snoop_dirty = 2'b10; bif2.snoop_shared = 2'b10;
        @(negedge clock);
        chk("dirty.grant", 8'(bif2.grant), 8'h1);
        @(negedge clock);
        chk("dirty.dbg2", 8'(bif2.dbg_state), 8'h2);
        @(negedge clock);
        chk("dirty.wb.cmd",  8'(bif2.mem_cmd),   8'h2);
        chk("dirty.wb.memv", 8'(bif2.mem_valid), 8'h1);
        chk("dirty.wb.dbg",  8'(bif2.dbg_state), 8'h3);
        @(negedge clock);
        chk("dirty.rd.cmd", 8'(bif2.mem_cmd),   8'h1);
        chk("dirty.rd.dbg", 8'(bif2.dbg_state), 8'h4);
        @(negedge clock);
        chk("dirty.done",    8'(bif2.done),        8'h1);
        chk("dirty.dshared", 8'(bif2.done_shared), 8'h1);
        chk("dirty.perr",    8'(bif2.protocol_err), 8'h0);
        bif2.req = 2'b00; bif2.snoop_dirty = 2'b00; bif2.snoop_shared = 2'b00;
        @(negedge clock);
        chk("dirty.idle", 8'(bif2.dbg_state), 8'h0);

        // Write miss from cache 1 with memory stalled three cycles in FETCH
        bif2.req = 2'b10; bif2.req_msg = 4'b1000; bif2.snoop_shared = 2'b01; bif2.mem_ready = 1'b0;
        @(negedge clock);
        chk("stall.grant",  8'(bif2.grant),   8'h2);
        chk("stall.busmsg", 8'(bif2.bus_msg), 8'h2);
        @(negedge clock);
        chk("stall.dbg2", 8'(bif2.dbg_state), 8'h2);
        bif2.req_msg = 4'b1100;
        @(negedge clock);
        chk("stall.c3.memv", 8'(bif2.mem_valid), 8'h1);
        chk("stall.c3.cmd",  8'(bif2.mem_cmd),   8'h1);
        @(negedge clock);
        chk("stall.c4.memv",   8'(bif2.mem_valid), 8'h1);
        chk("stall.c4.cmd",    8'(bif2.mem_cmd),   8'h1);
        chk("stall.c4.busmsg", 8'(bif2.bus_msg),   8'h2);
        @(negedge clock);
        chk("stall.c5.memv", 8'(bif2.mem_valid), 8'h1);
        chk("stall.c5.done", 8'(bif2.done),      8'h0);
        @(negedge clock);
        chk("stall.c6.dbg",  8'(bif2.dbg_state), 8'h4);
        chk("stall.c6.cmd",  8'(bif2.mem_cmd),   8'h1);
        bif2.mem_ready = 1'b1;
        @(negedge clock);
        chk("stall.done",    8'(bif2.done),        8'h2);
        chk("stall.dshared", 8'(bif2.done_shared), 8'h0);
        bif2.req = 2'b00; bif2.snoop_shared = 2'b00;
        @(negedge clock);
        chk("stall.idle", 8'(bif2.dbg_state), 8'h0);

        // Round-robin: both caches request continuously
        bif2.req = 2'b11; bif2.req_msg = 4'b0101; bif2.mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (bif2.done == '0 && n < 12);
            chk("rr.done",  8'(bif2.done),  (k % 2 == 0) ? 8'h1 : 8'h2);
            chk("rr.grant", 8'(bif2.grant), (k % 2 == 0) ? 8'h1 : 8'h2);
            chk("rr.lat",   8'(n),          (k == 0) ? 8'd4 : 8'd5);
        end
        bif2.req = 2'b00;
        @(negedge clock);
        chk("rr.idle", 8'(bif2.dbg_state), 8'h0);

        // Invalidate from cache 0 with one dirty peer: no memory traffic, no error
        bif2.req = 2'b01; bif2.req_msg = 4'b0011; bif2.snoop_dirty = 2'b10; bif2.mem_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk("inv2.done",    8'(bif2.done),         8'h1);
        chk("inv2.dshared", 8'(bif2.done_shared),  8'h0);
        chk("inv2.memv",    8'(bif2.mem_valid),    8'h0);
        chk("inv2.perr",    8'(bif2.protocol_err), 8'h0);
        bif2.req = 2'b00; bif2.snoop_dirty = 2'b00;
        @(negedge clock);

        // Three caches: invalidate from cache 1 with two dirty peers
        bif3.req = 3'b010; bif3.req_msg = 6'b001100; bif3.snoop_dirty = 3'b101;
        bif3.snoop_shared = 3'b101; bif3.mem_ready = 1'b1;
        @(negedge clock);
        chk("inv3.grant",  8'(bif3.grant),     8'h2);
        chk("inv3.busmsg", 8'(bif3.bus_msg),   8'h3);
        chk("inv3.memv1",  8'(bif3.mem_valid), 8'h0);
        @(negedge clock);
        chk("inv3.memv2", 8'(bif3.mem_valid),    8'h0);
        chk("inv3.perr0", 8'(bif3.protocol_err), 8'h0);
        @(negedge clock);
        chk("inv3.done",    8'(bif3.done),         8'h2);
        chk("inv3.dshared", 8'(bif3.done_shared),  8'h0);
        chk("inv3.memv3",   8'(bif3.mem_valid),    8'h0);
        chk("inv3.perr1",   8'(bif3.protocol_err), 8'h1);
        bif3.req = 3'b000; bif3.snoop_dirty = 3'b000; bif3.snoop_shared = 3'b000;
        repeat (3) @(negedge clock);
        chk("inv3.perr.sticky", 8'(bif3.protocol_err), 8'h1);
        chk("inv3.idle",        8'(bif3.dbg_state),    8'h0);

        // Reset in the middle of a stalled fetch
        bif2.req = 2'b01; bif2.req_msg = 4'b0001; bif2.mem_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk("abort.pre.dbg",  8'(bif2.dbg_state), 8'h4);
        chk("abort.pre.memv", 8'(bif2.mem_valid), 8'h1);
        #2 reset = 1'b1;
        #1;
        chk2_zero("abort.async");
        chk("abort.perr3", 8'(bif3.protocol_err), 8'h0);
        @(negedge clock);
        chk("abort.done", 8'(bif2.done),      8'h0);
        chk("abort.dbg",  8'(bif2.dbg_state), 8'h0);
        reset = 1'b0;
        bif2.req = 2'b11; bif2.req_msg = 4'b0101; bif2.mem_ready = 1'b1;
        @(negedge clock);
        chk("abort.next.grant", 8'(bif2.grant), 8'h1);
        repeat (3) @(negedge clock);
        chk("abort.next.done", 8'(bif2.done), 8'h1);
        bif2.req = 2'b00;
        @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion expected $finish before 100000");
        $fatal(1, "watchdog");
    end

endmodule
